// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, stall bit positions and stall patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  localparam logic STALL_YES = 1'b1;
  localparam logic STALL_NO  = 1'b0;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_MEM  = 5'b01111;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_ID   = 5'b00011;

  // A stage gets a NOP when the stage in front of it holds but it does not.
  function automatic logic [4:0] bubble_of(input logic [4:0] s);
    bubble_of = {s[3:0] & ~s[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Down-counter for the remaining cycles of a multi-cycle EX op: clear, load, hold, decrement.
module pipe_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble, multi-cycle EX sequencing and deferred flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       ex_mc_start,
  input  logic       mem_busy,
  input  logic       flush_req,
  output logic [4:0] stall,
  output logic [4:0] bubble,
  output logic       flush,
  output logic       mc_busy,
  output logic       mc_done
);

  localparam int CNT_W = $clog2(MC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

  state_e state_q;
  logic   pending_q;
  logic   flush_q;
  logic   mc_done_q;

  logic   cnt_zero_s;
  logic   go_flush_s;
  logic   start_s;
  logic   mc_end_s;
  logic   cnt_dec_s;
  logic [4:0] stall_s;

  always_comb begin
    go_flush_s = (flush_req | pending_q) & ~mem_busy;
    start_s    = (state_q == ST_RUN) & ex_mc_start & ~flush_req;
    mc_end_s   = (state_q == ST_MC_BUSY) & cnt_zero_s & ~mem_busy;
    cnt_dec_s  = (state_q == ST_MC_BUSY) & ~mem_busy & ~cnt_zero_s;
  end

  pipe_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .clr_i      (go_flush_s),
    .load_i     (start_s),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // Stall priority: FLUSH state, then memory wait, then multi-cycle EX, then load-use.
  always_comb begin
    stall_s = STALL_NONE;
    if (!rst) begin
      stall_s = STALL_NONE;
    end else if (state_q == ST_FLUSH) begin
      stall_s = STALL_NONE;
    end else if (mem_busy) begin
      stall_s = STALL_MEM;
    end else if ((state_q == ST_MC_BUSY) || ((state_q == ST_RUN) && ex_mc_start)) begin
      stall_s = STALL_EX;
    end else if (stallreq_id) begin
      stall_s = STALL_ID;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
      flush_q   <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      flush_q   <= 1'b0;
      mc_done_q <= 1'b0;
      if (go_flush_s) begin
        pending_q <= 1'b0;
      end else if (flush_req) begin
        pending_q <= 1'b1;
      end else begin
        pending_q <= pending_q;
      end
      // A flush aborts whatever is running, so an interrupted op never reports done.
      if (go_flush_s) begin
        state_q <= ST_FLUSH;
        flush_q <= 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            state_q <= start_s ? ST_MC_BUSY : ST_RUN;
          end
          ST_MC_BUSY: begin
            if (mc_end_s) begin
              state_q   <= ST_RUN;
              mc_done_q <= 1'b1;
            end else begin
              state_q <= ST_MC_BUSY;
            end
          end
          ST_FLUSH: begin
            state_q <= ST_RUN;
          end
          default: begin
            state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

  assign stall   = stall_s;
  assign bubble  = bubble_of(stall_s);
  assign flush   = flush_q;
  assign mc_busy = (state_q == ST_MC_BUSY);
  assign mc_done = mc_done_q;

endmodule
